// File: rtl/inst_aligner.sv
// Fetch-side instruction realigner.
// Buffers fetched 32-bit words as a circular queue of halfwords and hands one
// aligned instruction (16-bit compressed or 32-bit, possibly straddling a word
// boundary) to the decompressor per handshake. Also tracks the fetch and
// instruction PCs, including halfword-aligned redirects.
module inst_aligner #(
    parameter int                ADDR_W   = 32,
    parameter int                BUF_HW   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] fetch_addr_o,
    input  logic              fetch_valid_i,
    output logic              fetch_ready_o,
    input  logic [31:0]       fetch_data_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [31:0]       inst_o,
    output logic              compress_o,
    output logic [ADDR_W-1:0] pc_o
);

    localparam int PTR_W = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;
    localparam int CNT_W = $clog2(BUF_HW + 1);

    // Circular-pointer increment; explicit wrap keeps non-power-of-two depths legal.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_HW - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [15:0]       buf_q [BUF_HW];
    logic [15:0]       buf_d [BUF_HW];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              drop_q, drop_d;

    logic [15:0]       h0_s;
    logic [15:0]       h1_s;
    logic              compress_s;
    logic              inst_valid_s;
    logic              fetch_ready_s;
    logic              fetch_fire_s;
    logic              inst_fire_s;
    logic [CNT_W-1:0]  push_n_s;
    logic [CNT_W-1:0]  pop_n_s;
    logic              unused_pc0_s;

    // Bit 0 of the redirect target is architecturally always zero.
    assign unused_pc0_s = redirect_pc_i[0];

    assign h0_s          = buf_q[head_q];
    assign h1_s          = buf_q[ptr_inc(head_q)];
    assign compress_s    = (h0_s[1:0] != 2'b11);
    // Keep two free slots so a full word can always be pushed.
    assign fetch_ready_s = !redirect_i && (count_q <= CNT_W'(BUF_HW - 2));
    assign fetch_fire_s  = fetch_valid_i && fetch_ready_s;
    assign inst_fire_s   = inst_valid_s && inst_ready_i;

    // Instruction valid: decided by count first so stale buffer contents never matter when empty.
    always_comb begin
        inst_valid_s = 1'b0;
        if (redirect_i) begin
            inst_valid_s = 1'b0;
        end else if (count_q == CNT_W'(0)) begin
            inst_valid_s = 1'b0;
        end else if (compress_s) begin
            inst_valid_s = 1'b1;
        end else begin
            inst_valid_s = (count_q >= CNT_W'(2));
        end
    end

    // Next-state for buffer, pointers, PCs and drop flag; redirect overrides both handshakes.
    always_comb begin
        buf_d    = buf_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        pc_d     = pc_q;
        fpc_d    = fpc_q;
        drop_d   = drop_q;
        push_n_s = '0;
        pop_n_s  = '0;
        if (redirect_i) begin
            count_d = '0;
            head_d  = tail_q;
            pc_d    = {redirect_pc_i[ADDR_W-1:1], 1'b0};
            fpc_d   = {redirect_pc_i[ADDR_W-1:2], 2'b00};
            drop_d  = redirect_pc_i[1];
        end else begin
            if (fetch_fire_s) begin
                if (drop_q) begin
                    // Target PC is the upper halfword of this word; skip the lower one.
                    buf_d[tail_q] = fetch_data_i[31:16];
                    tail_d        = ptr_inc(tail_q);
                    push_n_s      = CNT_W'(1);
                    drop_d        = 1'b0;
                end else begin
                    buf_d[tail_q]          = fetch_data_i[15:0];
                    buf_d[ptr_inc(tail_q)] = fetch_data_i[31:16];
                    tail_d                 = ptr_inc(ptr_inc(tail_q));
                    push_n_s               = CNT_W'(2);
                end
                fpc_d = fpc_q + ADDR_W'(4);
            end else begin
                push_n_s = '0;
            end
            if (inst_fire_s) begin
                if (compress_s) begin
                    head_d  = ptr_inc(head_q);
                    pop_n_s = CNT_W'(1);
                    pc_d    = pc_q + ADDR_W'(2);
                end else begin
                    head_d  = ptr_inc(ptr_inc(head_q));
                    pop_n_s = CNT_W'(2);
                    pc_d    = pc_q + ADDR_W'(4);
                end
            end else begin
                pop_n_s = '0;
            end
            count_d = count_q + push_n_s - pop_n_s;
        end
    end

    // State registers with synchronous reset to the RESET_PC restart state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_HW; i++) begin
                buf_q[i] <= 16'h0000;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= {RESET_PC[ADDR_W-1:1], 1'b0};
            fpc_q   <= {RESET_PC[ADDR_W-1:2], 2'b00};
            drop_q  <= RESET_PC[1];
        end else begin
            buf_q   <= buf_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            fpc_q   <= fpc_d;
            drop_q  <= drop_d;
        end
    end

    assign fetch_addr_o  = fpc_q;
    assign fetch_ready_o = fetch_ready_s;
    assign inst_valid_o  = inst_valid_s;
    assign inst_o        = compress_s ? {16'h0000, h0_s} : {h1_s, h0_s};
    assign compress_o    = compress_s;
    assign pc_o          = pc_q;

endmodule

// File: tb/tb_inst_aligner.sv
// Self-checking bench for inst_aligner: table of small programs with expected
// instruction streams, plus directed sequences for reset, redirect, stall and
// redirect-during-handshake corners.
module tb_inst_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] fetch_addr_o;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic        compress_o;
    logic [31:0] pc_o;

    logic [31:0] mem [128];
    int          tests = 0;
    int          fails = 0;

    inst_aligner #(.ADDR_W(32), .BUF_HW(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .fetch_addr_o(fetch_addr_o), .fetch_valid_i(fetch_valid_i),
        .fetch_ready_o(fetch_ready_o), .fetch_data_i(fetch_data_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .compress_o(compress_o), .pc_o(pc_o)
    );

    always #5 clk = ~clk;

    assign fetch_data_i = mem[fetch_addr_o[8:2]];

    typedef struct packed {
        logic [31:0]       base;
        logic [2:0][31:0]  w;
        logic [3:0]        n;
        logic [2:0][31:0]  ei;
        logic [2:0][31:0]  ep;
        logic [2:0]        ec;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] base, input logic [31:0] w0, w1, w2,
                                input logic [3:0] n,
                                input logic [31:0] i0, p0, input logic c0,
                                input logic [31:0] i1, p1, input logic c1,
                                input logic [31:0] i2, p2, input logic c2);
        vec_t v;
        v.base = base;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        v.n = n;
        v.ei[0] = i0; v.ep[0] = p0; v.ec[0] = c0;
        v.ei[1] = i1; v.ep[1] = p1; v.ec[1] = c1;
        v.ei[2] = i2; v.ep[2] = p2; v.ec[2] = c2;
        return v;
    endfunction

    // One-cycle redirect; returns at the negedge after the redirect has taken effect.
    task automatic redir(input logic [31:0] addr);
        @(negedge clk);
        redirect_i    = 1'b1;
        redirect_pc_i = addr;
        @(negedge clk);
        redirect_i    = 1'b0;
    endtask

    // Collect n outputs with ready high and compare against expected stream.
    task automatic expect_stream(input int n, input logic [2:0][31:0] ei,
                                 input logic [2:0][31:0] ep, input logic [2:0] ec,
                                 input string tag);
        int got = 0;
        for (int cyc = 0; cyc < 20 && got < n; cyc++) begin
            if (inst_valid_o) begin
                chk({tag, " inst"}, inst_o, ei[got]);
                chk({tag, " pc"}, pc_o, ep[got]);
                chk({tag, " compress"}, {31'b0, compress_o}, {31'b0, ec[got]});
                got++;
            end
            @(negedge clk);
        end
        chk({tag, " count"}, got, n);
    endtask

    initial begin
        logic [2:0][31:0] ei;
        logic [2:0][31:0] ep;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0001_0001;
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        fetch_valid_i = 1'b1; inst_ready_i = 1'b1;

        // --- Reset state and first-output latency ---
        mem[0] = 32'h0000_0013; mem[1] = 32'h0000_0013; mem[2] = 32'h0000_0013;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst valid", {31'b0, inst_valid_o}, 32'h0);
        chk("rst fready", {31'b0, fetch_ready_o}, 32'h1);
        chk("rst faddr", fetch_addr_o, 32'h0);
        chk("rst pc", pc_o, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst-seq valid", {31'b0, inst_valid_o}, 32'h1);
            chk("rst-seq inst", inst_o, 32'h0000_0013);
            chk("rst-seq pc", pc_o, 32'(4 * k));
        end

        // --- Table of programs ---
        vecs[0] = mk(32'h000, 32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 4'd3,
                     32'h13, 32'h0, 1'b0, 32'h13, 32'h4, 1'b0, 32'h13, 32'h8, 1'b0);
        vecs[1] = mk(32'h000, 32'h4501_4501, 32'h0000_0013, 32'h0000_0013, 4'd2,
                     32'h4501, 32'h0, 1'b1, 32'h4501, 32'h2, 1'b1, 32'h0, 32'h0, 1'b0);
        vecs[2] = mk(32'h000, 32'h0013_4501, 32'h4501_0000, 32'h0000_0013, 4'd3,
                     32'h4501, 32'h0, 1'b1, 32'h13, 32'h2, 1'b0, 32'h4501, 32'h6, 1'b1);
        vecs[3] = mk(32'h102, 32'h0013_4501, 32'h4501_0000, 32'h0000_0013, 4'd2,
                     32'h13, 32'h102, 1'b0, 32'h4501, 32'h106, 1'b1, 32'h0, 32'h0, 1'b0);
        vecs[4] = mk(32'h020, 32'h0093_0001, 32'h4502_0000, 32'h0000_0013, 4'd3,
                     32'h0001, 32'h20, 1'b1, 32'h93, 32'h22, 1'b0, 32'h4502, 32'h26, 1'b1);
        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < 3; j++) mem[vecs[v].base[8:2] + 7'(j)] = vecs[v].w[j];
            redir(vecs[v].base);
            chk($sformatf("vec%0d post-redir valid", v), {31'b0, inst_valid_o}, 32'h0);
            expect_stream(int'(vecs[v].n), vecs[v].ei, vecs[v].ep, vecs[v].ec,
                          $sformatf("vec%0d", v));
        end

        // --- Redirect to 0x106 with non-empty buffer ---
        mem[64] = 32'h0000_0013; mem[65] = 32'h4501_0013; mem[66] = 32'h0000_0013;
        redir(32'h100);
        inst_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = 32'h106;
        #1;
        chk("r106 masked valid", {31'b0, inst_valid_o}, 32'h0);
        chk("r106 masked fready", {31'b0, fetch_ready_o}, 32'h0);
        @(negedge clk);
        redirect_i = 1'b0; inst_ready_i = 1'b1;
        chk("r106 faddr", fetch_addr_o, 32'h104);
        chk("r106 empty", {31'b0, inst_valid_o}, 32'h0);
        chk("r106 pc", pc_o, 32'h106);
        ei[0] = 32'h4501; ep[0] = 32'h106;
        ei[1] = 32'h13;   ep[1] = 32'h108;
        ei[2] = 32'h0;    ep[2] = 32'h0;
        expect_stream(2, ei, ep, 3'b001, "r106");

        // --- Stall 10 cycles, buffer fills, then release ---
        mem[16] = 32'h0013_4501; mem[17] = 32'h4501_0000;
        mem[18] = 32'h0000_0013; mem[19] = 32'h0000_0013;
        inst_ready_i = 1'b0;
        redir(32'h040);
        repeat (10) @(negedge clk);
        chk("stall fready", {31'b0, fetch_ready_o}, 32'h0);
        chk("stall faddr", fetch_addr_o, 32'h048);
        chk("stall pc", pc_o, 32'h040);
        inst_ready_i = 1'b1;
        ei[0] = 32'h4501; ep[0] = 32'h40;
        ei[1] = 32'h13;   ep[1] = 32'h42;
        ei[2] = 32'h4501; ep[2] = 32'h46;
        expect_stream(3, ei, ep, 3'b101, "stall");
        ei[0] = 32'h13; ep[0] = 32'h48;
        ei[1] = 32'h13; ep[1] = 32'h4C;
        expect_stream(2, ei, ep, 3'b000, "stall2");

        // --- Redirect while both handshakes would fire ---
        mem[32] = 32'h0000_0013;
        @(negedge clk);
        chk("rsim pre valid", {31'b0, inst_valid_o}, 32'h1);
        redirect_i = 1'b1; redirect_pc_i = 32'h080;
        #1;
        chk("rsim valid", {31'b0, inst_valid_o}, 32'h0);
        chk("rsim fready", {31'b0, fetch_ready_o}, 32'h0);
        @(negedge clk);
        redirect_i = 1'b0;
        chk("rsim next valid", {31'b0, inst_valid_o}, 32'h0);
        chk("rsim next pc", pc_o, 32'h080);
        chk("rsim next faddr", fetch_addr_o, 32'h080);
        ei[0] = 32'h13; ep[0] = 32'h80;
        expect_stream(1, ei, ep, 3'b000, "rsim");

        // --- Reset mid-operation ---
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst valid", {31'b0, inst_valid_o}, 32'h0);
        chk("mrst pc", pc_o, 32'h0);
        chk("mrst faddr", fetch_addr_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
